// File: rtl/subleq_datapath.sv
// ---------------------------------------------------------------------------
// subleq_datapath
//
// Datapath for a SUBLEQ ("subtract and branch if less than or equal to
// zero") processor. An external sequencer steps control_word through the
// phases of each instruction. Each instruction is three memory words at
// PC, PC+1 and PC+2, holding the addresses A and B and the jump target C.
// Each instruction performs mem[B] <= mem[B] - mem[A]. If the result is
// less than or equal to zero it jumps to C. Otherwise it continues at PC+3.
// A taken jump to a negative target stops the machine.
//
// Ports
//   clk          : clock, rising-edge
//   areset       : synchronous, active-high reset
//   control_word : current sequencer phase (FETCH_A .. FETCH_C, HALT)
//   halt         : stop request back to the sequencer
//   mem_addr     : memory address
//   mem_rdata    : memory read data, combinational from mem_addr
//   mem_wdata    : memory write data (non-zero only in STORE_SUB)
//   mem_we       : memory write enable, sampled by memory on clk
//   pc           : current program counter (debug)
// ---------------------------------------------------------------------------
module subleq_datapath #(
  parameter int                 WIDTH      = 16,
  parameter logic [WIDTH-1:0]   RESET_PC   = '0,
  parameter int                 STATE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [STATE_BITS-1:0] control_word,
  output logic                  halt,
  output logic [WIDTH-1:0]      mem_addr,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      pc
);

  localparam logic [STATE_BITS-1:0] CW_FETCH_A   = STATE_BITS'(0);
  localparam logic [STATE_BITS-1:0] CW_DEREF_A   = STATE_BITS'(1);
  localparam logic [STATE_BITS-1:0] CW_FETCH_B   = STATE_BITS'(2);
  localparam logic [STATE_BITS-1:0] CW_DEREF_B   = STATE_BITS'(3);
  localparam logic [STATE_BITS-1:0] CW_STORE_SUB = STATE_BITS'(4);
  localparam logic [STATE_BITS-1:0] CW_FETCH_C   = STATE_BITS'(5);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] va_q, va_d;
  logic [WIDTH-1:0] vb_q, vb_d;
  logic             leq_q, leq_d;
  logic             halted_q, halted_d;

  logic [WIDTH-1:0] sub_result;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] pc_plus2;
  logic [WIDTH-1:0] pc_plus3;
  logic             jump_to_negative;

  // All arithmetic wraps naturally at WIDTH bits; no overflow correction.
  assign sub_result = vb_q - va_q;
  assign pc_plus1   = pc_q + WIDTH'(1);
  assign pc_plus2   = pc_q + WIDTH'(2);
  assign pc_plus3   = pc_q + WIDTH'(3);

  // A taken jump whose target has its sign bit set is the stop condition.
  // It is visible in the same FETCH_C cycle, before HALTED is registered.
  assign jump_to_negative = (control_word == CW_FETCH_C) & leq_q & mem_rdata[WIDTH-1];
  assign halt             = halted_q | jump_to_negative;
  assign pc               = pc_q;

  always_comb begin
    pc_d      = pc_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    va_d      = va_q;
    vb_d      = vb_q;
    leq_d     = leq_q;
    halted_d  = halted_q;
    mem_addr  = pc_q;
    mem_wdata = '0;
    mem_we    = 1'b0;

    // Once halted, the datapath is frozen and parked on PC.
    // HALT and the unused code 6 take the default branch, so nothing changes.
    if (!halted_q) begin
      case (control_word)
        CW_FETCH_A: begin
          mem_addr = pc_q;
          ra_d     = mem_rdata;
        end
        CW_DEREF_A: begin
          mem_addr = ra_q;
          va_d     = mem_rdata;
        end
        CW_FETCH_B: begin
          mem_addr = pc_plus1;
          rb_d     = mem_rdata;
        end
        CW_DEREF_B: begin
          mem_addr = rb_q;
          vb_d     = mem_rdata;
        end
        CW_STORE_SUB: begin
          mem_addr  = rb_q;
          mem_wdata = sub_result;
          // Reset must suppress the write even in the middle of an instruction.
          mem_we    = ~areset;
          leq_d     = sub_result[WIDTH-1] | (sub_result == '0);
        end
        CW_FETCH_C: begin
          mem_addr = pc_plus2;
          pc_d     = leq_q ? mem_rdata : pc_plus3;
          if (jump_to_negative) begin
            halted_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      pc_q     <= RESET_PC;
      ra_q     <= '0;
      rb_q     <= '0;
      va_q     <= '0;
      vb_q     <= '0;
      leq_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      va_q     <= va_d;
      vb_q     <= vb_d;
      leq_q    <= leq_d;
      halted_q <= halted_d;
    end
  end

endmodule
